plic_claim_master: RTL

- Hart-side AXI4 initiator for one PLIC target context. It is the requester counterpart of the AXI-slave PLIC wrapper.
- When the PLIC raises irq for this context, the block reads the claim/complete register to obtain the interrupt ID and presents the ID to the core/handler logic.
- On handler completion it writes the same ID back to the claim/complete register.
- Sits between a PLIC `irq_o[k]` line and a crossbar master port.

---
 rtl/plic_claim_master_if.sv | 84 ++++++++
 rtl/plic_claim_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_master_if.sv
// AXI4 master-port bundle for plic_claim_master.
// The master modport is the initiator view; the slave modport is the
// responder view used by whatever sits on the crossbar side.
interface plic_claim_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2,
    parameter int STRB_W = DATA_W / 8
);
    // write address channel
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [3:0]        awregion;
    logic              awvalid;
    logic              awready;
    // write data channel
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    // write response channel
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    // read address channel
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [3:0]        arregion;
    logic              arvalid;
    logic              arready;
    // read data channel
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/plic_claim_master.sv
// plic_claim_master: hart-side AXI4 initiator for one PLIC target context.
// On irq_i it reads the claim/complete register, presents the claimed ID
// until done_i, then writes the ID back to complete the interrupt.
// Optional: define PLIC_CLAIM_STATS_EN to add claim/spurious/error counters.
module plic_claim_master #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ID_WIDTH   = 2,
    parameter int                        AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter logic [AXI_ID_WIDTH-1:0]   AXI_TXN_ID     = {AXI_ID_WIDTH{1'b0}},
    parameter logic [AXI_ADDR_WIDTH-1:0] PLIC_BASE_ADDR = 32'h0400_0000,
    parameter int                        TARGET_ID      = 0,
    parameter int                        SRCW           = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 irq_i,
    output logic [SRCW-1:0]      id_o,
    output logic                 id_valid_o,
    input  logic                 done_i,
    output logic                 busy_o,
    output logic                 spurious_o,
    output logic                 err_o,
    plic_claim_master_if.master  m_axi
`ifdef PLIC_CLAIM_STATS_EN
    ,
    output logic [31:0]          claim_cnt_o,
    output logic [31:0]          spurious_cnt_o,
    output logic [31:0]          err_cnt_o
`endif
);

    // Claim/complete register of this context; sum wraps at the address width.
    localparam logic [AXI_ADDR_WIDTH-1:0] CLAIM_OFFSET =
        AXI_ADDR_WIDTH'(32'h0020_0004 + 32'(TARGET_ID) * 32'h0000_1000);
    localparam logic [AXI_ADDR_WIDTH-1:0] CLAIM_ADDR = PLIC_BASE_ADDR + CLAIM_OFFSET;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        RD   = 3'd2,
        PEND = 3'd3,
        WR   = 3'd4,
        BR   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [SRCW-1:0] id_q, id_d;
    logic            id_valid_q, id_valid_d;
    logic            busy_q, busy_d;
    logic            spurious_q, spurious_d;
    logic            err_q, err_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic            ar_hs_s;
    logic            r_hit_s;
    logic            aw_hs_s;
    logic            w_hs_s;
    logic            b_hit_s;
    logic [SRCW-1:0] rd_id_s;
    logic            unused_s;

    // Responses carrying a foreign ID are not ours and are simply ignored.
    assign ar_hs_s  = arvalid_q & m_axi.arready;
    assign r_hit_s  = rready_q & m_axi.rvalid & (m_axi.rid == AXI_TXN_ID);
    assign aw_hs_s  = awvalid_q & m_axi.awready;
    assign w_hs_s   = wvalid_q & m_axi.wready;
    assign b_hit_s  = bready_q & m_axi.bvalid & (m_axi.bid == AXI_TXN_ID);
    assign rd_id_s  = m_axi.rdata[SRCW-1:0];
    assign unused_s = ^{m_axi.rlast, m_axi.rdata};

    // Next-state and registered-output decode for the claim/complete FSM.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        spurious_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (irq_i) begin
                    state_d = AR;
                end else begin
                    state_d = IDLE;
                end
            end
            AR: begin
                if (ar_hs_s) begin
                    state_d = RD;
                end else begin
                    state_d = AR;
                end
            end
            RD: begin
                if (r_hit_s) begin
                    id_d = rd_id_s;
                    if (m_axi.rresp != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (rd_id_s == {SRCW{1'b0}}) begin
                        spurious_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end else begin
                    state_d = RD;
                end
            end
            PEND: begin
                if (done_i) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR;
                end else begin
                    state_d = PEND;
                end
            end
            WR: begin
                // AW and W complete independently; leave once both are done.
                aw_done_d = aw_done_q | aw_hs_s;
                w_done_d  = w_done_q | w_hs_s;
                if (aw_done_d && w_done_d) begin
                    state_d = BR;
                end else begin
                    state_d = WR;
                end
            end
            BR: begin
                if (b_hit_s) begin
                    err_d   = (m_axi.bresp != RESP_OKAY);
                    state_d = IDLE;
                end else begin
                    state_d = BR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        arvalid_d  = (state_d == AR);
        rready_d   = (state_d == RD);
        awvalid_d  = (state_d == WR) && !aw_done_d;
        wvalid_d   = (state_d == WR) && !w_done_d;
        bready_d   = (state_d == BR);
        id_valid_d = (state_d == PEND);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= {SRCW{1'b0}};
            id_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            spurious_q <= 1'b0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            busy_q     <= busy_d;
            spurious_q <= spurious_d;
            err_q      <= err_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    assign id_o       = id_q;
    assign id_valid_o = id_valid_q;
    assign busy_o     = busy_q;
    assign spurious_o = spurious_q;
    assign err_o      = err_q;

    assign m_axi.arid     = AXI_TXN_ID;
    assign m_axi.araddr   = CLAIM_ADDR;
    assign m_axi.arlen    = 8'h00;
    assign m_axi.arsize   = 3'b010;
    assign m_axi.arburst  = 2'b01;
    assign m_axi.arlock   = 1'b0;
    assign m_axi.arcache  = 4'b0010;
    assign m_axi.arprot   = 3'b000;
    assign m_axi.arqos    = 4'h0;
    assign m_axi.arregion = 4'h0;
    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.rready   = rready_q;

    assign m_axi.awid     = AXI_TXN_ID;
    assign m_axi.awaddr   = CLAIM_ADDR;
    assign m_axi.awlen    = 8'h00;
    assign m_axi.awsize   = 3'b010;
    assign m_axi.awburst  = 2'b01;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = 4'b0010;
    assign m_axi.awprot   = 3'b000;
    assign m_axi.awqos    = 4'h0;
    assign m_axi.awregion = 4'h0;
    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.wdata    = {{(AXI_DATA_WIDTH-SRCW){1'b0}}, id_q};
    assign m_axi.wstrb    = {AXI_STRB_WIDTH{1'b1}};
    assign m_axi.wlast    = 1'b1;
    assign m_axi.wvalid   = wvalid_q;
    assign m_axi.bready   = bready_q;

`ifdef PLIC_CLAIM_STATS_EN
    logic [31:0] claim_cnt_q, claim_cnt_d;
    logic [31:0] spurious_cnt_q, spurious_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // Event counters; they wrap naturally at 32 bits.
    always_comb begin
        claim_cnt_d    = claim_cnt_q;
        spurious_cnt_d = spurious_cnt_q;
        err_cnt_d      = err_cnt_q;
        if ((state_q == RD) && (state_d == PEND)) begin
            claim_cnt_d = claim_cnt_q + 32'd1;
        end else begin
            claim_cnt_d = claim_cnt_q;
        end
        if (spurious_d) begin
            spurious_cnt_d = spurious_cnt_q + 32'd1;
        end else begin
            spurious_cnt_d = spurious_cnt_q;
        end
        if (err_d) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            claim_cnt_q    <= 32'd0;
            spurious_cnt_q <= 32'd0;
            err_cnt_q      <= 32'd0;
        end else begin
            claim_cnt_q    <= claim_cnt_d;
            spurious_cnt_q <= spurious_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign claim_cnt_o    = claim_cnt_q;
    assign spurious_cnt_o = spurious_cnt_q;
    assign err_cnt_o      = err_cnt_q;
`endif

endmodule
